// File: rtl/dcpu_bus_pkg.sv
// Shared definitions for the dcpu memory bus arbiter: FSM state encoding
// and bus field widths.
package dcpu_bus_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int SEL_W  = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2,
      ABORT  = 2'd3
   } bus_state_t;

endpackage

// File: rtl/dcpu_bus_watchdog.sv
// Bus stall watchdog: counts consecutive strobed cycles without ack and
// raises o_expire in the cycle the count would reach TIMEOUT.
module dcpu_bus_watchdog #(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 8
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_count,
   output logic o_expire
);

   localparam logic [CNT_W-1:0] LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

   logic [CNT_W-1:0] count;

   // Firing one count early lets a same-cycle ack (which drops i_count) win.
   assign o_expire = (TIMEOUT != 0) && i_count && (count == LAST);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         count <= '0;
      end else if (i_count && !o_expire) begin
         count <= count + CNT_W'(1);
      end else begin
         count <= '0;
      end
   end

endmodule

// File: rtl/dcpu_bus_arbiter.sv
// Two-master round-robin arbiter for the dcpu memory bus; grants are held
// for a whole cyc transaction and stalled transfers are aborted.
module dcpu_bus_arbiter
   import dcpu_bus_pkg::*;
#(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 8
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_m0_cyc,
   input  logic [SEL_W-1:0]  i_m0_stb,
   input  logic              i_m0_we,
   input  logic [ADDR_W-1:0] i_m0_addr,
   input  logic [DATA_W-1:0] i_m0_dat,
   output logic              o_m0_ack,
   output logic              o_m0_err,
   output logic [DATA_W-1:0] o_m0_dat,
   input  logic              i_m1_cyc,
   input  logic [SEL_W-1:0]  i_m1_stb,
   input  logic              i_m1_we,
   input  logic [ADDR_W-1:0] i_m1_addr,
   input  logic [DATA_W-1:0] i_m1_dat,
   output logic              o_m1_ack,
   output logic              o_m1_err,
   output logic [DATA_W-1:0] o_m1_dat,
   output logic              o_cyc,
   output logic [SEL_W-1:0]  o_stb,
   output logic              o_we,
   output logic [ADDR_W-1:0] o_addr,
   output logic [DATA_W-1:0] o_dat,
   input  logic              i_ack,
   input  logic [DATA_W-1:0] i_dat,
   output logic [1:0]        o_grant
);

   // state  | meaning
   // IDLE   | no owner, slave bus driven to zero
   // GRANT0 | master 0 owns the slave bus until it drops cyc
   // GRANT1 | master 1 owns the slave bus until it drops cyc
   // ABORT  | one-cycle watchdog abort, error pulse to last_owner

   bus_state_t state;
   logic       last_owner;
   logic       owner_holds;
   logic       wd_count;
   logic       wd_expire;

   always_comb begin
      o_cyc  = 1'b0;
      o_stb  = '0;
      o_we   = 1'b0;
      o_addr = '0;
      o_dat  = '0;
      case (state)
         GRANT0: begin
            o_cyc  = i_m0_cyc;
            o_stb  = i_m0_stb;
            o_we   = i_m0_we;
            o_addr = i_m0_addr;
            o_dat  = i_m0_dat;
         end
         GRANT1: begin
            o_cyc  = i_m1_cyc;
            o_stb  = i_m1_stb;
            o_we   = i_m1_we;
            o_addr = i_m1_addr;
            o_dat  = i_m1_dat;
         end
         default: begin
            o_cyc = 1'b0;
         end
      endcase
   end

   assign o_m0_ack = i_ack && (state == GRANT0);
   assign o_m1_ack = i_ack && (state == GRANT1);
   assign o_m0_dat = (state == GRANT0) ? i_dat : '0;
   assign o_m1_dat = (state == GRANT1) ? i_dat : '0;
   assign o_m0_err = (state == ABORT) && !last_owner;
   assign o_m1_err = (state == ABORT) && last_owner;
   assign o_grant  = {state == GRANT1, state == GRANT0};

   // Any ownership change drops the count term, which clears the watchdog.
   assign owner_holds = ((state == GRANT0) && i_m0_cyc) || ((state == GRANT1) && i_m1_cyc);
   assign wd_count    = owner_holds && (o_stb != '0) && !i_ack;

   dcpu_bus_watchdog #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) u_watchdog (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_count  (wd_count),
      .o_expire (wd_expire)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state      <= IDLE;
         last_owner <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (i_m0_cyc && i_m1_cyc) begin
                  state <= last_owner ? GRANT0 : GRANT1;
               end else if (i_m0_cyc) begin
                  state <= GRANT0;
               end else if (i_m1_cyc) begin
                  state <= GRANT1;
               end
            end
            GRANT0: begin
               if (!i_m0_cyc) begin
                  last_owner <= 1'b0;
                  state      <= i_m1_cyc ? GRANT1 : IDLE;
               end else if (wd_expire) begin
                  last_owner <= 1'b0;
                  state      <= ABORT;
               end
            end
            GRANT1: begin
               if (!i_m1_cyc) begin
                  last_owner <= 1'b1;
                  state      <= i_m0_cyc ? GRANT0 : IDLE;
               end else if (wd_expire) begin
                  last_owner <= 1'b1;
                  state      <= ABORT;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dcpu_bus_arbiter.sv
// Bench for dcpu_bus_arbiter: hand-built cycle table for the directed
// scenarios, then randomized traffic against an ownership-level model.
module tb_dcpu_bus_arbiter;

   localparam int TO = 4;

   logic        i_clk = 1'b0;
   logic        i_reset;
   logic        i_m0_cyc, i_m0_we, i_m1_cyc, i_m1_we;
   logic [3:0]  i_m0_stb, i_m1_stb;
   logic [31:0] i_m0_addr, i_m0_dat, i_m1_addr, i_m1_dat;
   logic        o_m0_ack, o_m0_err, o_m1_ack, o_m1_err;
   logic [31:0] o_m0_dat, o_m1_dat;
   logic        o_cyc, o_we;
   logic [3:0]  o_stb;
   logic [31:0] o_addr, o_dat;
   logic        i_ack;
   logic [31:0] i_dat;
   logic [1:0]  o_grant;

   int checks = 0;
   int errors = 0;

   dcpu_bus_arbiter #(.TIMEOUT(TO), .CNT_W(8)) dut (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_m0_cyc  (i_m0_cyc),
      .i_m0_stb  (i_m0_stb),
      .i_m0_we   (i_m0_we),
      .i_m0_addr (i_m0_addr),
      .i_m0_dat  (i_m0_dat),
      .o_m0_ack  (o_m0_ack),
      .o_m0_err  (o_m0_err),
      .o_m0_dat  (o_m0_dat),
      .i_m1_cyc  (i_m1_cyc),
      .i_m1_stb  (i_m1_stb),
      .i_m1_we   (i_m1_we),
      .i_m1_addr (i_m1_addr),
      .i_m1_dat  (i_m1_dat),
      .o_m1_ack  (o_m1_ack),
      .o_m1_err  (o_m1_err),
      .o_m1_dat  (o_m1_dat),
      .o_cyc     (o_cyc),
      .o_stb     (o_stb),
      .o_we      (o_we),
      .o_addr    (o_addr),
      .o_dat     (o_dat),
      .i_ack     (i_ack),
      .i_dat     (i_dat),
      .o_grant   (o_grant)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic       rst;
      logic       c0;
      logic [3:0] s0;
      logic       c1;
      logic [3:0] s1;
      logic       ack;
      logic       ecyc;
      logic [1:0] egnt;
      logic       ea0, ea1, ee0, ee1;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input int rst, input int c0, input int s0, input int c1,
                               input int s1, input int ack, input int ecyc, input int egnt,
                               input int ea0, input int ea1, input int ee0, input int ee1);
      vec_t r;
      r.rst  = 1'(rst);
      r.c0   = 1'(c0);
      r.s0   = 4'(s0);
      r.c1   = 1'(c1);
      r.s1   = 4'(s1);
      r.ack  = 1'(ack);
      r.ecyc = 1'(ecyc);
      r.egnt = 2'(egnt);
      r.ea0  = 1'(ea0);
      r.ea1  = 1'(ea1);
      r.ee0  = 1'(ee0);
      r.ee1  = 1'(ee1);
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ownership-level model: -1 none, 0/1 master, 2 abort cycle
   int owner, last, stall;

   initial begin
      logic [31:0] eaddr;
      logic [3:0]  estb;
      logic [1:0]  eg;
      logic        ecyc, ewe;
      logic [31:0] ewd;
      logic        oc, other;
      logic [3:0]  ostb;
      int          x;

      i_reset = 1'b1;
      i_m0_cyc = 1'b0; i_m0_stb = '0; i_m0_we = 1'b1; i_m0_addr = 32'h100; i_m0_dat = 32'h11111111;
      i_m1_cyc = 1'b0; i_m1_stb = '0; i_m1_we = 1'b0; i_m1_addr = 32'h200; i_m1_dat = 32'h22222222;
      i_ack = 1'b0; i_dat = 32'hDEADBEEF;
      repeat (2) @(posedge i_clk);
      #1;

      //          rst c0 s0  c1 s1 ack| cyc gnt a0 a1 e0 e1
      tbl.push_back(mk(0, 1, 15, 0, 0, 0,  0, 0, 0, 0, 0, 0)); // reset state, m0 request
      tbl.push_back(mk(0, 1, 15, 0, 0, 0,  1, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 15, 0, 0, 0,  1, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 15, 0, 0, 1,  1, 1, 1, 0, 0, 0)); // ack cycle 3
      tbl.push_back(mk(0, 0, 0,  0, 0, 0,  0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0, 0)); // reset before tie
      tbl.push_back(mk(0, 1, 15, 1, 3, 0,  0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 15, 1, 3, 0,  1, 1, 0, 0, 0, 0)); // m0 wins first tie
      tbl.push_back(mk(0, 0, 0,  1, 3, 0,  0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0,  1, 3, 0,  1, 2, 0, 0, 0, 0)); // no idle gap
      tbl.push_back(mk(0, 1, 15, 1, 3, 0,  1, 2, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 15, 1, 3, 0,  1, 2, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 15, 1, 3, 0,  1, 2, 0, 0, 0, 0)); // 4th stalled cycle
      tbl.push_back(mk(0, 1, 15, 1, 3, 0,  0, 0, 0, 0, 0, 1)); // ABORT
      tbl.push_back(mk(0, 1, 15, 1, 3, 0,  0, 0, 0, 0, 0, 0)); // IDLE
      tbl.push_back(mk(0, 1, 15, 1, 3, 0,  1, 1, 0, 0, 0, 0)); // m0 served next
      tbl.push_back(mk(0, 0, 0,  1, 3, 0,  0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0,  1, 3, 0,  1, 2, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0,  1, 3, 0,  1, 2, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0,  1, 3, 0,  1, 2, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0,  1, 3, 1,  1, 2, 0, 1, 0, 0)); // ack on boundary
      tbl.push_back(mk(0, 0, 0,  1, 3, 0,  1, 2, 0, 0, 0, 0)); // still granted
      tbl.push_back(mk(1, 1, 15, 1, 3, 0,  1, 2, 0, 0, 0, 0)); // reset mid-transfer
      tbl.push_back(mk(0, 1, 15, 1, 3, 0,  0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 15, 1, 3, 1,  1, 1, 1, 0, 0, 0)); // m0 first after reset
      tbl.push_back(mk(0, 0, 0,  0, 0, 0,  0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0,  0, 0, 1,  0, 0, 0, 0, 0, 0)); // ack while idle

      foreach (tbl[k]) begin
         i_reset  = tbl[k].rst;
         i_m0_cyc = tbl[k].c0;
         i_m0_stb = tbl[k].s0;
         i_m1_cyc = tbl[k].c1;
         i_m1_stb = tbl[k].s1;
         i_ack    = tbl[k].ack;
         @(negedge i_clk);
         eaddr = (tbl[k].egnt == 2'b01) ? 32'h100 : (tbl[k].egnt == 2'b10) ? 32'h200 : 32'h0;
         estb  = (tbl[k].egnt == 2'b01) ? tbl[k].s0 : (tbl[k].egnt == 2'b10) ? tbl[k].s1 : 4'h0;
         chk($sformatf("tbl%0d_grant", k), 64'(o_grant), 64'(tbl[k].egnt));
         chk($sformatf("tbl%0d_cyc", k), 64'(o_cyc), 64'(tbl[k].ecyc));
         chk($sformatf("tbl%0d_stb", k), 64'(o_stb), 64'(estb));
         chk($sformatf("tbl%0d_addr", k), 64'(o_addr), 64'(eaddr));
         chk($sformatf("tbl%0d_ack", k), 64'({o_m0_ack, o_m1_ack}), 64'({tbl[k].ea0, tbl[k].ea1}));
         chk($sformatf("tbl%0d_err", k), 64'({o_m0_err, o_m1_err}), 64'({tbl[k].ee0, tbl[k].ee1}));
         chk($sformatf("tbl%0d_rdat", k), {o_m0_dat, o_m1_dat},
             {tbl[k].egnt[0] ? 32'hDEADBEEF : 32'h0, tbl[k].egnt[1] ? 32'hDEADBEEF : 32'h0});
         @(posedge i_clk);
         #1;
      end

      // table leaves the arbiter idle with master 0 as the last owner
      owner = -1;
      last  = 0;
      stall = 0;

      for (int n = 0; n < 3000; n++) begin
         i_reset   = ($urandom_range(149) == 0);
         i_m0_cyc  = i_m0_cyc ? ($urandom_range(3) != 0) : ($urandom_range(2) == 0);
         i_m1_cyc  = i_m1_cyc ? ($urandom_range(3) != 0) : ($urandom_range(2) == 0);
         i_m0_stb  = 4'($urandom_range(15));
         i_m1_stb  = 4'($urandom_range(15));
         i_m0_we   = 1'($urandom_range(1));
         i_m1_we   = 1'($urandom_range(1));
         i_m0_addr = $urandom();
         i_m1_addr = $urandom();
         i_m0_dat  = $urandom();
         i_m1_dat  = $urandom();
         i_ack     = ($urandom_range(4) == 0);
         i_dat     = $urandom();
         @(negedge i_clk);

         eg = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
         if (owner == 0) begin
            ecyc = i_m0_cyc; estb = i_m0_stb; ewe = i_m0_we; eaddr = i_m0_addr; ewd = i_m0_dat;
         end else if (owner == 1) begin
            ecyc = i_m1_cyc; estb = i_m1_stb; ewe = i_m1_we; eaddr = i_m1_addr; ewd = i_m1_dat;
         end else begin
            ecyc = 1'b0; estb = 4'h0; ewe = 1'b0; eaddr = 32'h0; ewd = 32'h0;
         end
         chk("rnd_grant", 64'(o_grant), 64'(eg));
         chk("rnd_ctl", 64'({o_cyc, o_stb, o_we}), 64'({ecyc, estb, ewe}));
         chk("rnd_addr", 64'(o_addr), 64'(eaddr));
         chk("rnd_wdat", 64'(o_dat), 64'(ewd));
         chk("rnd_ack", 64'({o_m0_ack, o_m1_ack}), 64'({i_ack && owner == 0, i_ack && owner == 1}));
         chk("rnd_err", 64'({o_m0_err, o_m1_err}), 64'({owner == 2 && last == 0, owner == 2 && last == 1}));
         chk("rnd_rdat", {o_m0_dat, o_m1_dat},
             {(owner == 0) ? i_dat : 32'h0, (owner == 1) ? i_dat : 32'h0});

         if (i_reset) begin
            owner = -1; last = 1; stall = 0;
         end else if (owner == 2) begin
            owner = -1;
         end else if (owner < 0) begin
            if (i_m0_cyc && i_m1_cyc) owner = 1 - last;
            else if (i_m0_cyc)        owner = 0;
            else if (i_m1_cyc)        owner = 1;
         end else begin
            x     = owner;
            oc    = (x == 0) ? i_m0_cyc : i_m1_cyc;
            other = (x == 0) ? i_m1_cyc : i_m0_cyc;
            ostb  = (x == 0) ? i_m0_stb : i_m1_stb;
            if (!oc) begin
               last  = x;
               stall = 0;
               owner = other ? 1 - x : -1;
            end else if (ostb != 4'h0 && !i_ack) begin
               stall++;
               if (TO > 0 && stall >= TO) begin
                  owner = 2; last = x; stall = 0;
               end
            end else begin
               stall = 0;
            end
         end
         @(posedge i_clk);
         #1;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dcpu_bus_arbiter.md
Name: dcpu_bus_arbiter

Overview:
- Two-master to one-slave arbiter for the dcpu memory bus (cyc/stb/we/addr/dat/ack, 32-bit data, 4 byte-strobes).
- Lets the dcpu core (master 0) and a second requester such as DMA or debug (master 1) share one memory port.
- Arbitration is round-robin. A grant is held for the whole cyc transaction.
- A bus watchdog aborts a stalled transfer and reports it to the owning master with a one-cycle error pulse.

Parameters:
- TIMEOUT, 255: cycles of strobe without ack before abort; 0 disables the watchdog.
- CNT_W, 8: width of the watchdog counter; must satisfy 2**CNT_W > TIMEOUT.

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  synchronous active-high reset
- i_m0_cyc  in  1  master 0 bus cycle request
- i_m0_stb  in  4  master 0 byte strobes
- i_m0_we  in  1  master 0 write enable
- i_m0_addr  in  32  master 0 address
- i_m0_dat  in  32  master 0 write data
- o_m0_ack  out  1  ack to master 0
- o_m0_err  out  1  timeout error pulse to master 0
- o_m0_dat  out  32  read data to master 0
- i_m1_cyc, i_m1_stb, i_m1_we, i_m1_addr, i_m1_dat, o_m1_ack, o_m1_err, o_m1_dat: same widths and meaning for master 1
- o_cyc  out  1  slave bus cycle
- o_stb  out  4  slave byte strobes
- o_we  out  1  slave write enable
- o_addr  out  32  slave address
- o_dat  out  32  slave write data
- i_ack  in  1  slave ack
- i_dat  in  32  slave read data
- o_grant  out  2  one-hot current owner (debug/observation)

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_reset is synchronous and active-high; it overrides all other inputs at the edge.
- State machine: IDLE, GRANT0, GRANT1, ABORT. Reset enters IDLE with last_owner=1, so master 0 wins the first tie.
- IDLE transitions:
  - Only one master has cyc=1: go to that master's GRANTx.
  - Both have cyc=1: grant the master that is not last_owner.
  - No request: stay in IDLE.
  - Grant latency is one cycle: a request sampled at edge N drives the slave from cycle N+1.
- GRANTx, owner's cyc still 1: stay in GRANTx.
- GRANTx, owner drops cyc:
  - Set last_owner=x.
  - If the other master's cyc=1, go directly to GRANT(other) with no idle gap.
  - Otherwise go to IDLE.
- Slave bus muxing:
  - In GRANTx, o_cyc/o_stb/o_we/o_addr/o_dat follow master x combinationally.
  - In IDLE and ABORT, all slave outputs are 0.
- Return path to masters:
  - o_mX_ack = i_ack && state==GRANTx. The non-owner never sees ack.
  - o_mX_dat = i_dat when owner, else 0.
- Watchdog:
  - In GRANTx with o_stb!=0 and i_ack=0, the counter increments.
  - The counter clears on ack, on o_stb==0, or on any state change.
  - When the counter reaches TIMEOUT:
    - next state is ABORT and last_owner=x;
    - o_mX_err is high for exactly one cycle, the ABORT cycle;
    - o_cyc=0 during ABORT.
- ABORT exit: always IDLE next cycle, even if the aborted master still holds cyc. If that master still holds cyc, it may be regranted only by normal round-robin.
- TIMEOUT=0: the watchdog never fires.
- Ack in the same cycle the counter would reach TIMEOUT: the ack wins, no abort.
- Ack while the owner drops cyc in the same cycle: the ack is still routed, because it is combinational on the current state.
- Reset mid-transfer: next cycle is IDLE, all outputs 0, counter 0, last_owner=1.
- o_grant is 2'b01 in GRANT0, 2'b10 in GRANT1, 2'b00 otherwise.
- Reset values: o_cyc=0, o_stb=0, o_we=0, o_addr=0, o_dat=0, o_mX_ack=0, o_mX_err=0, o_mX_dat=0, o_grant=0.

Decomposition:
- Shared package dcpu_bus_pkg:
  - state encodings (IDLE=0, GRANT0=1, GRANT1=2, ABORT=3);
  - bus widths ADDR_W=32, DATA_W=32, SEL_W=4.
- One natural sub-module, dcpu_bus_watchdog: the counter with increment/clear/TIMEOUT compare producing a one-cycle expire pulse.
- The mux and FSM stay in the top module.

Test Plan:
- Single master: m0 cyc=1, stb=4'hF, addr=0x100. Slave acks at cycle 3 with i_dat=0xDEADBEEF.
  -> o_cyc rises one cycle after request; o_m0_ack=1 and o_m0_dat=0xDEADBEEF in the ack cycle; o_m1_ack stays 0.
- Simultaneous request just after reset: m0 and m1 both raise cyc.
  -> GRANT0 first. When m0 drops cyc, GRANT1 on the very next cycle with no IDLE gap; o_addr switches to m1's address.
- Fairness: both masters issue 4 back-to-back single-beat transactions.
  -> grants alternate 0,1,0,1,... and o_grant is never 2'b11.
- Timeout with TIMEOUT=4: m1 granted with stb=4'h3, i_ack held 0.
  -> After 4 strobed cycles, ABORT: o_cyc=0 and o_m1_err=1 for exactly one cycle, then IDLE; m0's pending request is granted next.
- Ack at boundary: ack arrives on the 4th strobed cycle with TIMEOUT=4.
  -> no abort; o_m1_ack=1 and o_m1_err stays 0.
- Reset mid-transfer: assert i_reset in GRANT1.
  -> next cycle all outputs 0; after release with both masters requesting, m0 is granted first.
